// File: rtl/uart_rom_loader.sv
// uart_rom_loader: 8N1 UART boot loader that writes a length-prefixed,
// big-endian 16-bit word image into the instruction memory write port and
// holds the CPU in reset until the image is complete.
// Optional feature macro: UART_ROM_LOADER_CHECKSUM_EN (trailing XOR byte check).
// ADDR_WIDTH is expected to be at most 16 (the length field is 16 bits).
module uart_rom_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [15:0]           rom_in,
  output logic                  rom_load,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF      = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0] MAX_WORDS    = 17'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE,
`ifdef UART_ROM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rom_address_q;
  logic [15:0]           rom_in_q;
  logic                  rom_load_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;
  logic [7:0]            count_hi_q;
  logic [15:0]           remain_q;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
  logic [7:0]            xor_q;
`endif

  logic [15:0] n_words;
  logic        too_long;

  assign n_words  = {count_hi_q, shift_q};
  assign too_long = {1'b0, n_words} > MAX_WORDS;

  assign rom_address = rom_address_q;
  assign rom_in      = rom_in_q;
  assign rom_load    = rom_load_q;
  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign error       = error_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // 8N1 receiver: mid-bit sampling, false-start rejection, framing check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            cnt_q      <= HALF_M1;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              cnt_q      <= BIT_M1;
              bit_idx_q  <= '0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_sync_q, shift_q[7:1]};
            cnt_q   <= BIT_M1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                   bit_idx_q  <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Loader FSM: length header, word assembly, one-cycle write strobe, release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LEN_HI;
      rom_address_q <= '0;
      rom_in_q      <= '0;
      rom_load_q    <= 1'b0;
      cpu_reset_q   <= 1'b1;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      count_hi_q    <= '0;
      remain_q      <= '0;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      rom_load_q <= 1'b0;
      if (frame_err_q && state_q != DONE && state_q != ERROR) begin
        state_q <= ERROR;
        error_q <= 1'b1;
      end else begin
        case (state_q)
          LEN_HI: begin
            if (byte_valid_q) begin
              count_hi_q <= shift_q;
              state_q    <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (byte_valid_q) begin
              remain_q <= n_words;
              if (n_words == 16'd0) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
                state_q <= CHECK;
`else
                state_q     <= DONE;
                cpu_reset_q <= 1'b0;
                done_q      <= 1'b1;
`endif
              end else if (too_long) begin
                state_q <= ERROR;
                error_q <= 1'b1;
              end else begin
                state_q <= DATA_HI;
              end
            end
          end
          DATA_HI: begin
            if (byte_valid_q) begin
              rom_in_q[15:8] <= shift_q;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              xor_q <= xor_q ^ shift_q;
`endif
              state_q <= DATA_LO;
            end
          end
          DATA_LO: begin
            if (byte_valid_q) begin
              rom_in_q[7:0] <= shift_q;
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              xor_q <= xor_q ^ shift_q;
`endif
              rom_load_q <= 1'b1;
              state_q    <= WRITE;
            end
          end
          WRITE: begin
            rom_address_q <= rom_address_q + ADDR_WIDTH'(1);
            remain_q      <= remain_q - 16'd1;
            if (remain_q == 16'd1) begin
`ifdef UART_ROM_LOADER_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q     <= DONE;
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else begin
              state_q <= DATA_HI;
            end
          end
`ifdef UART_ROM_LOADER_CHECKSUM_EN
          CHECK: begin
            if (byte_valid_q) begin
              if (shift_q == xor_q) begin
                state_q     <= DONE;
                cpu_reset_q <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                state_q <= ERROR;
                error_q <= 1'b1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rom_loader.md
Name: uart_rom_loader

Overview:
- Serial boot loader that sits directly upstream of the instruction memory.
- Receives a program image over an 8N1 UART line and writes it word-by-word into the instruction memory's write port (address/in/load).
- Holds the CPU in reset until the image is fully written.
- Replaces the fixed synthesis-time program file, so new programs load without rebuilding the bitstream.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_WIDTH, 15, instruction memory address width; maximum image = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- rx  input  1  UART serial input, idle high, asynchronous to clk
- rom_address  output  ADDR_WIDTH  write address to instruction memory
- rom_in  output  16  write data to instruction memory
- rom_load  output  1  one-cycle write strobe to instruction memory
- cpu_reset  output  1  active-high hold for CPU reset; high while loading
- done  output  1  image fully written; CPU released
- error  output  1  framing, length or (optional) checksum fault; sticky until reset

Behaviour:
- Reset (reset=0, async) values:
  - rom_address=0, rom_in=0, rom_load=0
  - cpu_reset=1, done=0, error=0
  - receiver idle, FSM in LEN_HI
- rx passes through a 2-flop synchronizer before any use; it is initialised high on reset.
- Receiver:
  - Start detect: synchronized rx falls 1->0 while idle.
  - Re-sample at CLKS_PER_BIT/2. If rx is high, it is a false start: return to idle with no byte and no error.
  - Sample 8 data bits LSB first, each CLKS_PER_BIT cycles after the previous sample, then the stop bit.
  - Stop=1: byte_valid pulses for exactly 1 cycle with the byte.
  - Stop=0: framing error. The FSM enters ERROR.
- Byte stream protocol (all big-endian):
  - Word count N as 2 bytes.
  - Then N words, each sent as a high byte followed by a low byte.
- FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, (CHECK), DONE, ERROR.
- Transitions:
  - LEN_HI: on byte -> latch count[15:8] -> LEN_LO.
  - LEN_LO: on byte -> latch count[7:0].
    - N=0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERROR.
    - Otherwise -> DATA_HI.
  - DATA_HI: on byte -> rom_in[15:8] -> DATA_LO.
  - DATA_LO: on byte -> rom_in[7:0] -> WRITE.
  - WRITE: rom_load=1 for exactly one cycle with stable rom_address and rom_in.
    - Next cycle rom_address increments and the remaining count decrements.
    - Remaining count reaches 0 -> DONE (or CHECK when the optional feature is enabled); else -> DATA_HI.
  - DONE: cpu_reset=0, done=1. Further rx traffic is ignored and never writes memory. Only reset leaves DONE.
  - ERROR: error=1, cpu_reset stays 1, no further writes. Only reset leaves ERROR.
- Write timing: the WRITE cycle follows the DATA_LO byte_valid cycle by exactly 1 clk. Byte-to-write latency is 1 cycle.
- rom_address after a full 2^ADDR_WIDTH-word image wraps to 0. No write is issued after the wrap.
- A framing error in any state other than DONE -> ERROR.
- cpu_reset and done change in the same cycle the FSM enters DONE.
- Reset asserted mid-frame or mid-image:
  - Everything aborts immediately; a rom_load in progress deasserts asynchronously.
  - Loading restarts at LEN_HI, address 0.
  - Partially written memory contents are undefined.

Optional Feature:
- Macro: UART_ROM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, FSM enters CHECK and waits for one extra byte.
  - That byte must equal the XOR of all 2N data bytes; length bytes are excluded. XOR accumulator resets to 0 at reset.
  - Match -> DONE; mismatch -> ERROR.
  - N=0 also requires a checksum byte of 0x00.
- Undefined: no CHECK state; the FSM enters DONE directly after the last WRITE; no checksum byte is expected.

Test Plan (CLKS_PER_BIT=4, ADDR_WIDTH=4):
- Send 00 02 12 34 AB CD -> two rom_load pulses: (addr 0, 0x1234) then (addr 1, 0xABCD). Then done=1, cpu_reset=0, error=0.
- Send 00 00 -> no rom_load; done=1 within 2 cycles of the second stop bit (checksum build: after trailing 00).
- Send 00 11 (17 > 16) -> error=1, cpu_reset=1, no rom_load; subsequent bytes cause no writes.
- Send a 0-pulse shorter than CLKS_PER_BIT/2 on rx, then 00 01 BE EF -> glitch ignored; single write (addr 0, 0xBEEF), done=1.
- Send byte 0x12 with stop bit=0 during DATA_HI -> error=1, rom_load never asserted. Then pulse reset low mid-frame, resend 00 01 00 07 -> write (addr 0, 0x0007), done=1, error=0.
- Checksum build: 00 01 12 34 26 -> done=1; 00 01 12 34 27 -> error=1, cpu_reset stays 1.
